// File: rtl/vec_mul_sequencer.sv
// vec_mul_sequencer: control FSM for the vector-multiply datapath.
//
// A job is requested with start while idle. The sequencer then:
//   - drives the weight-slot address and pulses weight_reload to the array,
//   - streams num_vecs Unified Buffer read addresses, one per cycle,
//   - tracks each read through a PIPE_LATENCY-deep valid delay line and issues
//     the matching result-SRAM write enable and address,
//   - pulses done once the last result has been written.
//
// Ports:
//   clk              rising-edge clock
//   rstn             synchronous reset, ACTIVE HIGH despite the name
//   start            job request, sampled only in IDLE
//   num_vecs         vectors in the job (latched at start)
//   ub_base          first UB read address (latched at start)
//   res_base         first result write address (latched at start)
//   weight_sel       weight slot (latched at start)
//   busy             high from the cycle after an accepted start through DONE
//   done             one-cycle pulse at job end
//   fifo_address     weight-slot address to the weight SRAM (valid in WLOAD)
//   weight_reload    weight load strobe to the array
//   ub_read          ub_address valid this cycle
//   ub_address       UB read address
//   res_write_enable result-SRAM write strobe
//   res_address      result-SRAM write address (holds between writes)
//   perf_cycles      busy-cycle counter, present only with VEC_SEQ_PERF_EN
//
// Optional feature: define VEC_SEQ_PERF_EN to add perf_cycles[15:0], a saturating
// count of busy cycles that clears on each accepted start.

module vec_mul_sequencer #(
    parameter int ADDRESSSIZE      = 10,
    parameter int ADDRESSSIZE_fifo = 2,
    parameter int WLOAD_CYCLES     = 1,
    parameter int PIPE_LATENCY     = 34
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [ADDRESSSIZE-1:0]      num_vecs,
    input  logic [ADDRESSSIZE-1:0]      ub_base,
    input  logic [ADDRESSSIZE-1:0]      res_base,
    input  logic [ADDRESSSIZE_fifo-1:0] weight_sel,
    output logic                        busy,
    output logic                        done,
    output logic [ADDRESSSIZE_fifo-1:0] fifo_address,
    output logic                        weight_reload,
    output logic                        ub_read,
    output logic [ADDRESSSIZE-1:0]      ub_address,
    output logic                        res_write_enable,
    output logic [ADDRESSSIZE-1:0]      res_address
`ifdef VEC_SEQ_PERF_EN
    ,
    output logic [15:0]                 perf_cycles
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StStream,
        StDrain,
        StDone
    } state_e;

    localparam logic [3:0] WloadLast = 4'(WLOAD_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [3:0]                  wl_cnt_q, wl_cnt_d;
    logic [ADDRESSSIZE-1:0]      vec_cnt_q, vec_cnt_d;   // reads still to issue
    logic [ADDRESSSIZE-1:0]      ub_addr_q, ub_addr_d;
    logic [ADDRESSSIZE-1:0]      res_addr_q, res_addr_d;
    logic [ADDRESSSIZE_fifo-1:0] wsel_q, wsel_d;
    logic [PIPE_LATENCY-1:0]     pipe_q, pipe_d;         // valid bit per in-flight vector
    logic                        accept;

    always_comb begin
        state_d       = state_q;
        wl_cnt_d      = wl_cnt_q;
        vec_cnt_d     = vec_cnt_q;
        ub_addr_d     = ub_addr_q;
        res_addr_d    = res_addr_q;
        wsel_d        = wsel_q;
        accept        = 1'b0;
        busy          = (state_q != StIdle);
        done          = 1'b0;
        fifo_address  = '0;
        weight_reload = 1'b0;
        ub_read       = 1'b0;
        ub_address    = '0;

        res_write_enable = pipe_q[PIPE_LATENCY-1];
        res_address      = res_addr_q;
        // The pipe is always empty in IDLE, so a write never collides with the
        // reload of res_addr at accept below.
        if (res_write_enable) begin
            res_addr_d = res_addr_q + ADDRESSSIZE'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept     = 1'b1;
                    wsel_d     = weight_sel;
                    ub_addr_d  = ub_base;
                    res_addr_d = res_base;
                    vec_cnt_d  = num_vecs;
                    wl_cnt_d   = '0;
                    state_d    = (num_vecs == '0) ? StDone : StWload;
                end
            end
            StWload: begin
                fifo_address  = wsel_q;
                weight_reload = 1'b1;
                if (wl_cnt_q == WloadLast) begin
                    state_d = StStream;
                end else begin
                    wl_cnt_d = wl_cnt_q + 4'd1;
                end
            end
            StStream: begin
                ub_read    = 1'b1;
                ub_address = ub_addr_q;
                ub_addr_d  = ub_addr_q + ADDRESSSIZE'(1);
                vec_cnt_d  = vec_cnt_q - ADDRESSSIZE'(1);
                if (vec_cnt_q == ADDRESSSIZE'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Only the last stage may still be set: it is written this cycle
                // and the line is empty once we enter DONE.
                if (pipe_q[PIPE_LATENCY-2:0] == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pipe_d = {pipe_q[PIPE_LATENCY-2:0], ub_read};
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= StIdle;
            wl_cnt_q   <= '0;
            vec_cnt_q  <= '0;
            ub_addr_q  <= '0;
            res_addr_q <= '0;
            wsel_q     <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            wl_cnt_q   <= wl_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            ub_addr_q  <= ub_addr_d;
            res_addr_q <= res_addr_d;
            wsel_q     <= wsel_d;
            pipe_q     <= pipe_d;
        end
    end

`ifdef VEC_SEQ_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (rstn) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    always_comb begin
        perf_cycles = perf_q;
    end
`endif

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench for vec_mul_sequencer. Events (weight reloads, reads,
// writes, done) are logged with their cycle number and compared against
// timings and addresses computed from the job parameters.
module tb_vec_mul_sequencer;

    localparam int AW   = 10;
    localparam int FW   = 2;
`ifdef VEC_SEQ_PERF_EN
    localparam int WL   = 3;
`else
    localparam int WL   = 1;
`endif
    localparam int PL   = 34;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] num_vecs;
    logic [AW-1:0] ub_base;
    logic [AW-1:0] res_base;
    logic [FW-1:0] weight_sel;
    logic          busy;
    logic          done;
    logic [FW-1:0] fifo_address;
    logic          weight_reload;
    logic          ub_read;
    logic [AW-1:0] ub_address;
    logic          res_write_enable;
    logic [AW-1:0] res_address;
`ifdef VEC_SEQ_PERF_EN
    logic [15:0]   perf_cycles;
`endif

    vec_mul_sequencer #(
        .ADDRESSSIZE      (AW),
        .ADDRESSSIZE_fifo (FW),
        .WLOAD_CYCLES     (WL),
        .PIPE_LATENCY     (PL)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .num_vecs         (num_vecs),
        .ub_base          (ub_base),
        .res_base         (res_base),
        .weight_sel       (weight_sel),
        .busy             (busy),
        .done             (done),
        .fifo_address     (fifo_address),
        .weight_reload    (weight_reload),
        .ub_read          (ub_read),
        .ub_address       (ub_address),
        .res_write_enable (res_write_enable),
        .res_address      (res_address)
`ifdef VEC_SEQ_PERF_EN
        ,
        .perf_cycles      (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen; the cycle after edge t reads cyc == t.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cyc[$], rd_addr[$], wr_cyc[$], wr_addr[$], wl_cyc[$], wl_fifo[$], done_cyc[$];

    always @(negedge clk) begin
        if (ub_read === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(ub_address));
        end
        if (res_write_enable === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(res_address));
        end
        if (weight_reload === 1'b1) begin
            wl_cyc.push_back(cyc);
            wl_fifo.push_back(int'(fifo_address));
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic clear_logs();
        rd_cyc.delete(); rd_addr.delete(); wr_cyc.delete(); wr_addr.delete();
        wl_cyc.delete(); wl_fifo.delete(); done_cyc.delete();
    endtask

    // Drive one accepted start; t is the cycle number in which busy first shows.
    task automatic start_job(input int n, input int ub, input int rb, input int ws,
                             output int t);
        @(negedge clk);
        num_vecs   = AW'(n);
        ub_base    = AW'(ub);
        res_base   = AW'(rb);
        weight_sel = FW'(ws);
        start      = 1'b1;
        @(posedge clk);
        #1;
        t          = cyc;
        start      = 1'b0;
        // Scramble inputs: the running job must ignore them.
        num_vecs   = AW'($urandom);
        ub_base    = AW'($urandom);
        res_base   = AW'($urandom);
        weight_sel = FW'($urandom);
    endtask

    task automatic wait_cycle(input int target);
        for (int g = 0; g < 2000; g++) begin
            @(negedge clk);
            if (cyc >= target) break;
        end
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        start = 1'b0;
        num_vecs = '0; ub_base = '0; res_base = '0; weight_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, weight_reload, ub_read, res_write_enable} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, weight_reload, ub_read, res_write_enable});
        end
        tests_run++;
        if ({fifo_address, ub_address, res_address} !== '0) begin
            tests_failed++;
            $display("FAIL reset_addr: got fifo=%0d ub=%0d res=%0d want 0",
                     fifo_address, ub_address, res_address);
        end
`ifdef VEC_SEQ_PERF_EN
        tests_run++;
        if (perf_cycles !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_perf: got %0d want 0", perf_cycles);
        end
`endif
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic test_basic();
        int n, ub, rb, ws, t, dc;
        for (int j = 0; j < 5; j++) begin
            if (j == 0) begin
                n = 4; ub = 10; rb = 100; ws = 2;
            end else begin
                n  = int'($urandom_range(1, 24));
                ub = int'($urandom_range(0, AMOD - 1));
                rb = int'($urandom_range(0, AMOD - 1));
                ws = int'($urandom_range(0, 3));
            end
            clear_logs();
            start_job(n, ub, rb, ws, t);
            tests_run++;
            if (busy !== 1'b1 || weight_reload !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_first_cycle job%0d: got busy=%b reload=%b want 1 1",
                         j, busy, weight_reload);
            end
            wait_done(WL + n + PL + 20, dc);
            tests_run++;
            if (wl_cyc.size() != WL) begin
                tests_failed++;
                $display("FAIL basic_reload_len job%0d: got %0d want %0d", j, wl_cyc.size(), WL);
            end
            for (int i = 0; i < wl_cyc.size() && i < WL; i++) begin
                tests_run++;
                if (wl_cyc[i] != t + i || wl_fifo[i] != ws) begin
                    tests_failed++;
                    $display("FAIL basic_reload job%0d[%0d]: got cyc=%0d fifo=%0d want %0d %0d",
                             j, i, wl_cyc[i], wl_fifo[i], t + i, ws);
                end
            end
            tests_run++;
            if (rd_cyc.size() != n || wr_cyc.size() != n) begin
                tests_failed++;
                $display("FAIL basic_counts job%0d: got rd=%0d wr=%0d want %0d",
                         j, rd_cyc.size(), wr_cyc.size(), n);
            end
            for (int i = 0; i < rd_cyc.size() && i < n; i++) begin
                tests_run++;
                if (rd_cyc[i] != t + WL + i || rd_addr[i] != (ub + i) % AMOD) begin
                    tests_failed++;
                    $display("FAIL basic_read job%0d[%0d]: got cyc=%0d addr=%0d want %0d %0d",
                             j, i, rd_cyc[i], rd_addr[i], t + WL + i, (ub + i) % AMOD);
                end
            end
            for (int i = 0; i < wr_cyc.size() && i < n; i++) begin
                tests_run++;
                if (wr_cyc[i] != t + WL + i + PL || wr_addr[i] != (rb + i) % AMOD) begin
                    tests_failed++;
                    $display("FAIL basic_write job%0d[%0d]: got cyc=%0d addr=%0d want %0d %0d",
                             j, i, wr_cyc[i], wr_addr[i], t + WL + i + PL, (rb + i) % AMOD);
                end
            end
            tests_run++;
            if (dc != t + WL + n + PL) begin
                tests_failed++;
                $display("FAIL basic_done job%0d: got cyc=%0d want %0d", j, dc, t + WL + n + PL);
            end
            tests_run++;
            if (busy !== 1'b0 || done_cyc.size() != 1) begin
                tests_failed++;
                $display("FAIL basic_idle job%0d: got busy=%b dones=%0d want 0 1",
                         j, busy, done_cyc.size());
            end
        end
    endtask

    task automatic test_zero_length();
        int t;
        clear_logs();
        start_job(0, 5, 6, 1, t);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_done: got busy=%b done=%b want 1 1", busy, done);
        end
        repeat (PL + 5) @(negedge clk);
        tests_run++;
        if (wl_cyc.size() + rd_cyc.size() + wr_cyc.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_activity: got reload=%0d rd=%0d wr=%0d want 0",
                     wl_cyc.size(), rd_cyc.size(), wr_cyc.size());
        end
        tests_run++;
        if (done_cyc.size() != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_single_done: got dones=%0d busy=%b want 1 0",
                     done_cyc.size(), busy);
        end
    endtask

    task automatic test_wrap();
        int t, dc;
        int exp_rd[3];
        int exp_wr[3];
        exp_rd = '{1022, 1023, 0};
        exp_wr = '{1023, 0, 1};
        clear_logs();
        start_job(3, 1022, 1023, 0, t);
        wait_done(WL + 3 + PL + 20, dc);
        tests_run++;
        if (rd_addr.size() != 3 || wr_addr.size() != 3) begin
            tests_failed++;
            $display("FAIL wrap_counts: got rd=%0d wr=%0d want 3",
                     rd_addr.size(), wr_addr.size());
        end
        for (int i = 0; i < 3 && i < rd_addr.size() && i < wr_addr.size(); i++) begin
            tests_run++;
            if (rd_addr[i] != exp_rd[i] || wr_addr[i] != exp_wr[i]) begin
                tests_failed++;
                $display("FAIL wrap_addr[%0d]: got ub=%0d res=%0d want %0d %0d",
                         i, rd_addr[i], wr_addr[i], exp_rd[i], exp_wr[i]);
            end
        end
    endtask

    task automatic test_busy_reject();
        int t, dc;
        clear_logs();
        start_job(5, 200, 300, 3, t);
        wait_cycle(t + WL + 1);
        num_vecs = AW'(7);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(WL + 5 + PL + 20, dc);
        repeat (WL + PL + 20) @(negedge clk);
        tests_run++;
        if (rd_cyc.size() != 5 || wr_cyc.size() != 5) begin
            tests_failed++;
            $display("FAIL reject_counts: got rd=%0d wr=%0d want 5",
                     rd_cyc.size(), wr_cyc.size());
        end
        tests_run++;
        if (done_cyc.size() != 1 || dc != t + WL + 5 + PL || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_done: got dones=%0d cyc=%0d busy=%b want 1 %0d 0",
                     done_cyc.size(), dc, busy, t + WL + 5 + PL);
        end
    endtask

    task automatic test_back_to_back();
        int t, td, dc, t2;
        clear_logs();
        start_job(2, 40, 50, 1, t);
        td = t + WL + 2 + PL;
        wait_cycle(td);
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done_cycle: got done=%b want 1", done);
        end
        // start during DONE must be dropped
        num_vecs = AW'(6);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (WL + PL + 20) @(negedge clk);
        tests_run++;
        if (rd_cyc.size() != 2 || done_cyc.size() != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done_start: got rd=%0d dones=%0d busy=%b want 2 1 0",
                     rd_cyc.size(), done_cyc.size(), busy);
        end
        clear_logs();
        start_job(3, 1000, 1021, 2, t2);
        wait_done(WL + 3 + PL + 20, dc);
        tests_run++;
        if (dc != t2 + WL + 3 + PL || wr_addr.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_second_job: got done=%0d writes=%0d want %0d 3",
                     dc, wr_addr.size(), t2 + WL + 3 + PL);
        end
    endtask

    task automatic test_reset_abort();
        int t, dc, rb;
        clear_logs();
        start_job(3, int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)), 1, t);
        wait_cycle(t + WL + 3 + 5);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, weight_reload, ub_read, res_write_enable} !== 5'b0 ||
            {fifo_address, ub_address, res_address} !== '0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got flags=%b res=%0d want 0",
                     {busy, done, weight_reload, ub_read, res_write_enable}, res_address);
        end
        @(negedge clk);
        rstn = 1'b0;
        repeat (PL + 20) @(negedge clk);
        tests_run++;
        if (done_cyc.size() != 0 || wr_cyc.size() != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got dones=%0d writes=%0d want 0 0",
                     done_cyc.size(), wr_cyc.size());
        end
        clear_logs();
        rb = int'($urandom_range(0, AMOD - 1));
        start_job(1, 77, rb, 0, t);
        wait_done(WL + 1 + PL + 20, dc);
        tests_run++;
        if (dc != t + WL + 1 + PL || wr_addr.size() != 1) begin
            tests_failed++;
            $display("FAIL abort_next_job: got done=%0d writes=%0d want %0d 1",
                     dc, wr_addr.size(), t + WL + 1 + PL);
        end else begin
            tests_run++;
            if (wr_addr[0] != rb || wr_cyc[0] != t + WL + PL) begin
                tests_failed++;
                $display("FAIL abort_next_write: got addr=%0d cyc=%0d want %0d %0d",
                         wr_addr[0], wr_cyc[0], rb, t + WL + PL);
            end
        end
    endtask

`ifdef VEC_SEQ_PERF_EN
    task automatic test_perf();
        int t, dc;
        clear_logs();
        start_job(8, 3, 4, 1, t);
        wait_done(WL + 8 + PL + 20, dc);
        tests_run++;
        if (perf_cycles !== 16'(WL + 8 + PL + 1)) begin
            tests_failed++;
            $display("FAIL perf_count: got %0d want %0d", perf_cycles, WL + 8 + PL + 1);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (perf_cycles !== 16'(WL + 8 + PL + 1)) begin
            tests_failed++;
            $display("FAIL perf_hold: got %0d want %0d", perf_cycles, WL + 8 + PL + 1);
        end
        start_job(0, 0, 0, 0, t);
        tests_run++;
        if (perf_cycles !== 16'd0) begin
            tests_failed++;
            $display("FAIL perf_clear: got %0d want 0", perf_cycles);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (perf_cycles !== 16'd1) begin
            tests_failed++;
            $display("FAIL perf_zero_job: got %0d want 1", perf_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_busy_reject();
        test_back_to_back();
        test_reset_abort();
`ifdef VEC_SEQ_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
